// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the 5-bit LFSR stream
// (feedback s[2]^s[3], new bit shifted into s[1]). It loads its register
// from the stream, confirms the prediction over CONFIRM_LEN bits, then
// free-runs its own copy and counts bits and mismatches while locked.
//
// Only s[3:1] is kept: the prediction s[2]^s[3] never reads s[4] or s[5],
// so those stages would only hold bits that are shifted out unused.
module prbs_checker #(
  parameter int CONFIRM_LEN = 8,
  parameter int LOSS_THRESH = 3,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               clear_counts,
  output logic               locked,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] bit_count,
  output logic [COUNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0]         CONFIRM_LAST = 8'(CONFIRM_LEN - 1);
  localparam logic [7:0]         LOSS_LAST    = 8'(LOSS_THRESH - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;

  state_t             state_q, state_d;
  logic [3:1]         s_q, s_d;
  logic [2:0]         load_cnt_q, load_cnt_d;
  logic [7:0]         match_cnt_q, match_cnt_d;
  logic [7:0]         miss_cnt_q, miss_cnt_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [COUNT_W-1:0] bit_count_q, bit_count_d;
  logic [COUNT_W-1:0] err_count_q, err_count_d;
  logic               pred;
  logic [3:1]         s_loaded;

  // Next-state, register shift, internal counters and output flops for one valid bit.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    load_cnt_d  = load_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    pred        = s_q[2] ^ s_q[3];
    s_loaded    = {s_q[2:1], bit_in};

    if (bit_valid) begin
      case (state_q)
        ST_LOAD: begin
          s_d = s_loaded;
          if (load_cnt_q == 3'd4) begin
            load_cnt_d = 3'd0;
            if (s_loaded != 3'b000) begin
              state_d     = ST_CONFIRM;
              match_cnt_d = 8'd0;
            end
          end else begin
            load_cnt_d = load_cnt_q + 3'd1;
          end
        end

        ST_CONFIRM: begin
          s_d = s_loaded;
          if (bit_in == pred) begin
            match_cnt_d = match_cnt_q + 8'd1;
            if (match_cnt_q == CONFIRM_LAST) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 8'd0;
            end
          end else begin
            state_d    = ST_LOAD;
            load_cnt_d = 3'd0;
          end
        end

        ST_LOCKED: begin
          s_d = {s_q[2:1], pred};
          if (bit_count_q != COUNT_MAX) begin
            bit_count_d = bit_count_q + COUNT_W'(1);
          end
          if (bit_in != pred) begin
            err_pulse_d = 1'b1;
            miss_cnt_d  = miss_cnt_q + 8'd1;
            if (err_count_q != COUNT_MAX) begin
              err_count_d = err_count_q + COUNT_W'(1);
            end
            if (miss_cnt_q == LOSS_LAST) begin
              state_d    = ST_LOAD;
              load_cnt_d = 3'd0;
            end
          end else begin
            miss_cnt_d = 8'd0;
          end
        end

        default: begin
          state_d    = ST_LOAD;
          load_cnt_d = 3'd0;
        end
      endcase
    end

    if (clear_counts) begin
      bit_count_d = '0;
      err_count_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      s_q         <= 3'b000;
      load_cnt_q  <= 3'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      load_cnt_q  <= load_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign bit_count = bit_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scenarios plus a randomized stream, checked
// against a behavioural model built on a bit-history queue.
module tb_prbs_checker;

  localparam int CONFIRM_LEN = 8;
  localparam int LOSS_THRESH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_counts;
  logic        locked, err_pulse;
  logic [15:0] bit_count, err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  bit_count4, err_count4;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: acquisition mode, history of register contents, counts since clear.
  int m_mode;
  bit m_hist[$];
  int m_loaded, m_match, m_miss;
  int m_bits, m_errs;
  bit m_pulse;

  bit pat[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  int pidx = 0;

  prbs_checker #(.CONFIRM_LEN(CONFIRM_LEN), .LOSS_THRESH(LOSS_THRESH), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_counts(clear_counts), .locked(locked), .err_pulse(err_pulse),
    .bit_count(bit_count), .err_count(err_count)
  );

  prbs_checker #(.CONFIRM_LEN(CONFIRM_LEN), .LOSS_THRESH(LOSS_THRESH), .COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_counts(clear_counts), .locked(locked4), .err_pulse(err_pulse4),
    .bit_count(bit_count4), .err_count(err_count4)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function bit next_bit();
    bit b;
    b = pat[pidx];
    pidx = (pidx + 1) % 7;
    return b;
  endfunction

  function void model_reset();
    m_mode = 0;
    m_hist.delete();
    m_loaded = 0; m_match = 0; m_miss = 0;
    m_bits = 0; m_errs = 0;
    m_pulse = 1'b0;
  endfunction

  function void model_step(input bit b, input bit v, input bit c);
    int  n;
    bit  pr;
    m_pulse = 1'b0;
    if (v) begin
      n = m_hist.size();
      if (m_mode == 0) begin
        m_hist.push_back(b);
        m_loaded++;
        if (m_loaded == 5) begin
          n = m_hist.size();
          m_loaded = 0;
          if (m_hist[n-1] | m_hist[n-2] | m_hist[n-3]) begin
            m_mode = 1;
            m_match = 0;
          end
        end
      end else if (m_mode == 1) begin
        pr = m_hist[n-2] ^ m_hist[n-3];
        m_hist.push_back(b);
        if (b == pr) begin
          m_match++;
          if (m_match == CONFIRM_LEN) begin
            m_mode = 2;
            m_miss = 0;
          end
        end else begin
          m_mode = 0;
          m_loaded = 0;
        end
      end else begin
        pr = m_hist[n-2] ^ m_hist[n-3];
        m_hist.push_back(pr);
        m_bits++;
        if (b != pr) begin
          m_errs++;
          m_pulse = 1'b1;
          m_miss++;
          if (m_miss == LOSS_THRESH) begin
            m_mode = 0;
            m_loaded = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
      while (m_hist.size() > 8) void'(m_hist.pop_front());
    end
    if (c) begin
      m_bits = 0;
      m_errs = 0;
    end
  endfunction

  task automatic drive(input bit b, input bit v, input bit c);
    @(negedge clk);
    bit_in = b; bit_valid = v; clear_counts = c;
    @(posedge clk);
    model_step(b, v, c);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clear_counts = 1'b0;
    #12;
    model_reset();
    pidx = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_locked: got %0b expected 0", locked); end
    n_cmp++;
    if (err_pulse !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err_pulse: got %0b expected 0", err_pulse); end
    n_cmp++;
    if (bit_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++; $display("[TB] FAIL reset_counts: got bits=%0d errs=%0d expected 0/0", bit_count, err_count);
    end
  endtask

  task automatic test_clean_lock();
    int lost = 0;
    for (int i = 1; i <= 13; i++) begin
      drive(next_bit(), 1'b1, 1'b0);
      if (i == 12) begin
        n_cmp++;
        if (locked !== 1'b0) begin n_bad++; $display("[TB] FAIL clean_not_locked_12: got %0b expected 0", locked); end
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin n_bad++; $display("[TB] FAIL clean_locked_13: got %0b expected 1", locked); end
    for (int i = 0; i < 100; i++) begin
      drive(next_bit(), 1'b1, 1'b0);
      if (locked !== 1'b1) lost++;
    end
    n_cmp++;
    if (lost != 0) begin n_bad++; $display("[TB] FAIL clean_stays_locked: lost in %0d cycles expected 0", lost); end
    n_cmp++;
    if (bit_count !== 16'd100 || err_count !== 16'd0) begin
      n_bad++; $display("[TB] FAIL clean_counts: got bits=%0d errs=%0d expected 100/0", bit_count, err_count);
    end
  endtask

  task automatic test_single_flip();
    drive(1'b0, 1'b0, 1'b1);
    drive(~next_bit(), 1'b1, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_bad++; $display("[TB] FAIL flip_detect: got pulse=%0b errs=%0d locked=%0b expected 1/1/1", err_pulse, err_count, locked);
    end
    drive(next_bit(), 1'b1, 1'b0);
    n_cmp++;
    if (err_pulse !== 1'b0) begin n_bad++; $display("[TB] FAIL flip_pulse_width: got %0b expected 0", err_pulse); end
    for (int i = 0; i < 49; i++) drive(next_bit(), 1'b1, 1'b0);
    n_cmp++;
    if (err_count !== 16'd1 || locked !== 1'b1 || bit_count !== 16'd51) begin
      n_bad++; $display("[TB] FAIL flip_no_corruption: got errs=%0d locked=%0b bits=%0d expected 1/1/51", err_count, locked, bit_count);
    end
  endtask

  task automatic test_loss_of_lock();
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      drive(~next_bit(), 1'b1, 1'b0);
      n_cmp++;
      if (locked !== (i < 3) || err_pulse !== 1'b1) begin
        n_bad++; $display("[TB] FAIL loss_flip_%0d: got locked=%0b pulse=%0b expected %0b/1", i, locked, err_pulse, (i < 3));
      end
    end
    n_cmp++;
    if (err_count !== 16'd3 || bit_count !== 16'd3) begin
      n_bad++; $display("[TB] FAIL loss_counts: got errs=%0d bits=%0d expected 3/3", err_count, bit_count);
    end
    for (int i = 1; i <= 13; i++) begin
      drive(next_bit(), 1'b1, 1'b0);
      if (i == 12 || i == 13) begin
        n_cmp++;
        if (locked !== (i == 13)) begin n_bad++; $display("[TB] FAIL relock_%0d: got %0b expected %0b", i, locked, (i == 13)); end
      end
    end
  endtask

  task automatic test_all_zero();
    int seen = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (locked !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0 || bit_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++; $display("[TB] FAIL all_zero: got locked_cycles=%0d bits=%0d errs=%0d expected 0/0/0", seen, bit_count, err_count);
    end
  endtask

  task automatic test_gapped_lock();
    int cycles = 0;
    int gap_pulses = 0;
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (err_pulse !== 1'b0) gap_pulses++;
      drive(next_bit(), 1'b1, 1'b0);
      cycles += 2;
      if (i == 12 || i == 13) begin
        n_cmp++;
        if (locked !== (i == 13)) begin n_bad++; $display("[TB] FAIL gapped_lock_%0d: got %0b expected %0b", i, locked, (i == 13)); end
      end
    end
    n_cmp++;
    if (gap_pulses != 0 || cycles != 26) begin
      n_bad++; $display("[TB] FAIL gapped_timing: got gap_pulses=%0d cycles=%0d expected 0/26", gap_pulses, cycles);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) drive(next_bit(), 1'b1, 1'b0);
    n_cmp++;
    if (bit_count4 !== 4'd15 || bit_count !== 16'd20) begin
      n_bad++; $display("[TB] FAIL sat_bits: got w4=%0d w16=%0d expected 15/20", bit_count4, bit_count);
    end
    for (int i = 0; i < 40; i++) begin
      bit b;
      b = next_bit();
      drive((i % 2 == 0) ? ~b : b, 1'b1, 1'b0);
    end
    n_cmp++;
    if (err_count4 !== 4'd15 || err_count !== 16'd20 || bit_count !== 16'd60 || locked !== 1'b1) begin
      n_bad++; $display("[TB] FAIL sat_errs: got e4=%0d e16=%0d b16=%0d locked=%0b expected 15/20/60/1",
                        err_count4, err_count, bit_count, locked);
    end
  endtask

  task automatic test_clear_on_error();
    drive(~next_bit(), 1'b1, 1'b1);
    n_cmp++;
    if (err_pulse !== 1'b1 || bit_count !== 16'd0 || err_count !== 16'd0 || err_count4 !== 4'd0) begin
      n_bad++; $display("[TB] FAIL clear_wins: got pulse=%0b bits=%0d errs=%0d e4=%0d expected 1/0/0/0",
                        err_pulse, bit_count, err_count, err_count4);
    end
  endtask

  task automatic test_reset_mid_lock();
    drive(next_bit(), 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(~next_bit(), 1'b1, 1'b0);
    drive(next_bit(), 1'b1, 1'b0);
    drive(~next_bit(), 1'b1, 1'b0);
    n_cmp++;
    if (err_count !== 16'd2 || locked !== 1'b1 || err_pulse !== 1'b1) begin
      n_bad++; $display("[TB] FAIL pre_reset: got errs=%0d locked=%0b pulse=%0b expected 2/1/1", err_count, locked, err_pulse);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || bit_count !== 16'd0 || err_count !== 16'd0) begin
      n_bad++; $display("[TB] FAIL async_reset: got locked=%0b pulse=%0b bits=%0d errs=%0d expected 0/0/0/0",
                        locked, err_pulse, bit_count, err_count);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 13; i++) begin
      drive(next_bit(), 1'b1, 1'b0);
      if (i == 12 || i == 13) begin
        n_cmp++;
        if (locked !== (i == 13)) begin n_bad++; $display("[TB] FAIL reset_relock_%0d: got %0b expected %0b", i, locked, (i == 13)); end
      end
    end
  endtask

  task automatic test_random();
    logic [43:0] got, exp;
    int burst = 0;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      bit v, c, b;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      if (i % 150 == 149) burst = $urandom_range(3, 12);
      if (burst > 0) begin
        b = 1'($urandom_range(0, 1));
        if (v) burst--;
      end else if (v) begin
        b = next_bit();
        if ($urandom_range(0, 15) == 0) b = ~b;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      drive(b, v, c);
      got = {locked, err_pulse, bit_count, err_count, locked4, err_pulse4, bit_count4, err_count4};
      exp = {(m_mode == 2), m_pulse, 16'(sat(m_bits, 16)), 16'(sat(m_errs, 16)),
             (m_mode == 2), m_pulse, 4'(sat(m_bits, 4)), 4'(sat(m_errs, 4))};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("[TB] FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_loss_of_lock();
    test_all_zero();
    test_gapped_lock();
    test_saturation();
    test_clear_on_error();
    test_reset_mid_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
